shared_memory_responder: RTL and testbench

//   Memory-side responder for the four-core non-coherent memory example: the target end of the rd/wr/rdy

---
 rtl/coherency_pkg.sv | 28 ++
 rtl/rr_arbiter_4.sv | 38 +++
 rtl/shared_memory_responder.sv | 189 ++++++++++++++++++
 tb/tb_shared_memory_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/coherency_pkg.sv
// -----------------------------------------------------------------------------
// coherency_pkg
//   Shared definitions for the four-core non-coherent memory example.
//   - N_PORTS           : number of requesting ports (cores/caches)
//   - DEF_DATA_W/ADDR_W : default store geometry
//   - DEF_LATENCY       : default request-to-rdy latency
//   - state_e           : responder FSM encodings ST_IDLE/ST_BUSY/ST_RESP
//   - next_ptr()        : round-robin pointer advance (wraps 3 -> 0)
// -----------------------------------------------------------------------------
package coherency_pkg;

  localparam int N_PORTS     = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_LATENCY = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // The pointer is two bits wide, so the natural overflow gives the 3 -> 0 wrap.
  function automatic logic [1:0] next_ptr(input logic [1:0] g);
    return g + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//   Combinational four-way round-robin picker. Grants the first requester found
//   when scanning upward from ptr, wrapping 3 -> 0.
// Ports
//   req     in  [3:0]  request vector, bit i = port i
//   ptr     in  [1:0]  highest-priority port for this decision
//   gnt     out [3:0]  one-hot grant (all zero when req is zero)
//   gnt_idx out [1:0]  index of the granted port (equals ptr when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter_4
  import coherency_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    idx     = ptr;
    for (int k = 0; k < N_PORTS; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/shared_memory_responder.sv
// -----------------------------------------------------------------------------
// shared_memory_responder
//   Memory-side target of the four-core rd/wr/rdy request interface. Requests
//   from the four ports are arbitrated round-robin; exactly one access is in
//   flight at a time and completes with a one-cycle rdy pulse LATENCY cycles
//   after it was accepted. The backing store is a plain register array with no
//   coherency between ports.
//
// Handshake (valid/ready): a port raises rd or wr (rd&wr = write) with addr and
//   wdata and holds all of them stable until the cycle in which its rdy is 1.
//   rdy is a single-cycle pulse; rdata for that port is valid in that same
//   cycle and holds its value afterwards. A new request may start the cycle
//   after rdy.
//
// Optional feature (macro MEM_REQ_CHECK_EN): adds the proto_err output, a
//   sticky per-port flag for rd&wr together, or for a granted port changing
//   addr/wdata or dropping its request before rdy. Datapath is unchanged.
//
// Parameters
//   DATA_W   data width per port
//   ADDR_W   word address width (store depth 2**ADDR_W)
//   LATENCY  acceptance-to-rdy latency, legal 2..15
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   rd, wr     in   [3:0] per-port read / write request
//   addr       in   [4*ADDR_W-1:0] port i at [i*ADDR_W +: ADDR_W]
//   wdata      in   [4*DATA_W-1:0] port i at [i*DATA_W +: DATA_W]
//   rdy        out  [3:0] per-port completion pulse
//   rdata      out  [4*DATA_W-1:0] per-port read data
//   proto_err  out  [3:0] sticky protocol error (MEM_REQ_CHECK_EN only)
// -----------------------------------------------------------------------------
module shared_memory_responder
  import coherency_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        rd,
  input  logic [N_PORTS-1:0]        wr,
  input  logic [N_PORTS*ADDR_W-1:0] addr,
  input  logic [N_PORTS*DATA_W-1:0] wdata,
  output logic [N_PORTS-1:0]        rdy,
  output logic [N_PORTS*DATA_W-1:0] rdata
`ifdef MEM_REQ_CHECK_EN
  ,
  output logic [N_PORTS-1:0]        proto_err
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  // BUSY counts down from LATENCY-1 and leaves at 1, so IDLE + (LATENCY-1)
  // BUSY cycles + RESP gives rdy exactly LATENCY cycles after acceptance.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                     state_q,  state_d;
  logic [3:0]                 cnt_q,    cnt_d;
  logic [1:0]                 ptr_q,    ptr_d;
  logic [1:0]                 gidx_q,   gidx_d;
  logic                       op_wr_q,  op_wr_d;
  logic [ADDR_W-1:0]          addr_q,   addr_d;
  logic [DATA_W-1:0]          wdata_q,  wdata_d;
  logic [N_PORTS*DATA_W-1:0]  rdata_q,  rdata_d;
  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [DATA_W-1:0]          mem_d [DEPTH];

  logic [3:0]                 gnt;
  logic [1:0]                 gnt_idx;

  rr_arbiter_4 u_arb (
    .req     (rd | wr),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Next-state and output logic of the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mem_d   = mem_q;
    rdy     = '0;

    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          state_d = ST_BUSY;
          gidx_d  = gnt_idx;
          op_wr_d = wr[gnt_idx];
          addr_d  = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          wdata_d = wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          cnt_d   = CNT_INIT;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          // Read data is captured on entry to RESP so it is registered and
          // valid alongside rdy. The store cannot change in between because
          // only this access is in flight, and any write lands at the end of
          // RESP, so a read never sees a same-cycle write.
          if (!op_wr_q) begin
            rdata_d[int'(gidx_q)*DATA_W +: DATA_W] = mem_q[addr_q];
          end
        end
      end

      ST_RESP: begin
        rdy[gidx_q] = 1'b1;
        if (op_wr_q) begin
          mem_d[addr_q] = wdata_q;
        end
        ptr_d   = next_ptr(gidx_q);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mem_q   <= mem_d;
    end
  end

  assign rdata = rdata_q;

`ifdef MEM_REQ_CHECK_EN
  logic [N_PORTS-1:0] perr_q, perr_d;

  // Holding is only checked in BUSY: during RESP the port already sees its
  // rdy and is allowed to let go of the request in that cycle.
  always_comb begin
    perr_d = perr_q | (rd & wr);
    if (state_q == ST_BUSY) begin
      if (!(rd[gidx_q] | wr[gidx_q]) ||
          (addr[int'(gidx_q)*ADDR_W +: ADDR_W] != addr_q) ||
          (wdata[int'(gidx_q)*DATA_W +: DATA_W] != wdata_q)) begin
        perr_d[gidx_q] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_q <= '0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign proto_err = perr_q;
`endif

endmodule

// File: tb/tb_shared_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_shared_memory_responder
//   Directed bench for shared_memory_responder (DATA_W=8, ADDR_W=4, LATENCY=3).
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_shared_memory_responder;

  localparam int LAT = 3;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        rst;
  logic [3:0]  rd;
  logic [3:0]  wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [3:0]  rdy;
  logic [31:0] rdata;
`ifdef MEM_REQ_CHECK_EN
  logic [3:0]  proto_err;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  shared_memory_responder #(
    .DATA_W  (8),
    .ADDR_W  (4),
    .LATENCY (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd        (rd),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .rdy       (rdy),
    .rdata     (rdata)
`ifdef MEM_REQ_CHECK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];
  logic [7:0] expd_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic set_port(input int p, input bit r, input bit w,
                          input logic [3:0] a, input logic [7:0] d);
    rd[p] = r;
    wr[p] = w;
    addr[p*4 +: 4]  = a;
    wdata[p*8 +: 8] = d;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    rd = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Waits (bounded) for rdy[p]; lat counts falling edges since the request was
  // driven. Every cycle the other ports' rdy must be low.
  task automatic wait_rdy(input int p, input int start, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = start;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      check("other_rdy_zero", 32'(rdy & ~(4'b0001 << p)), 32'h0);
      if (rdy[p]) seen = 1'b1;
    end
    check("rdy_seen", 32'(seen), 32'h1);
  endtask

  // One complete access on port p; for reads the returned data is compared.
  task automatic access(input int p, input bit r, input bit w, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp, input string nm);
    int lat;
    @(negedge clk);
    set_port(p, r, w, a, d);
    wait_rdy(p, 0, lat);
    check({nm, "_latency"}, 32'(lat), 32'(LAT));
    if (!w) check({nm, "_rdata"}, 32'(rdata[p*8 +: 8]), 32'(exp));
    set_port(p, 1'b0, 1'b0, a, d);
    @(negedge clk);
    check({nm, "_rdy_pulse"}, 32'(rdy), 32'h0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int         port;
    bit         r;
    bit         w;
    logic [3:0] a;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int since;
    int served;
    int lat;
    bit rearm0;
    logic [1:0] p;
    logic [7:0] d;

    // Ends with a port-3 access so the round-robin pointer is back at 0.
    vecs[0] = '{0, 1'b1, 1'b0, 4'h5, 8'h00, 8'h00};
    vecs[1] = '{2, 1'b0, 1'b1, 4'h5, 8'hA5, 8'h00};
    vecs[2] = '{1, 1'b1, 1'b0, 4'h5, 8'h00, 8'hA5};
    vecs[3] = '{3, 1'b1, 1'b0, 4'h6, 8'h00, 8'h00};
    vecs[4] = '{0, 1'b0, 1'b1, 4'hF, 8'h5A, 8'h00};
    vecs[5] = '{3, 1'b1, 1'b0, 4'hF, 8'h00, 8'h5A};
    vecs[6] = '{1, 1'b0, 1'b1, 4'h0, 8'hFF, 8'h00};
    vecs[7] = '{2, 1'b1, 1'b0, 4'h0, 8'h00, 8'hFF};
    vecs[8] = '{3, 1'b1, 1'b0, 4'h5, 8'h00, 8'hA5};

    rst = 1'b1;
    rd = '0; wr = '0; addr = '0; wdata = '0;
    #2;
    apply_reset();
    @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'h0);
    check("reset_rdata", rdata, 32'h0);
`ifdef MEM_REQ_CHECK_EN
    check("reset_proto_err", 32'(proto_err), 32'h0);
`endif

    // Single-port accesses from the table.
    for (int i = 0; i < 9; i++) begin
      access(vecs[i].port, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp,
             $sformatf("vec%0d", i));
    end

    // All four ports request together; port 0 re-requests right after its rdy.
    exp_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    expd_q = '{8'hA5, 8'hFF, 8'h5A, 8'h00, 8'hFF};
    @(negedge clk);
    set_port(0, 1'b1, 1'b0, 4'h5, 8'h00);
    set_port(1, 1'b1, 1'b0, 4'h0, 8'h00);
    set_port(2, 1'b1, 1'b0, 4'hF, 8'h00);
    set_port(3, 1'b1, 1'b0, 4'h6, 8'h00);
    since = 0; served = 0; rearm0 = 1'b0;
    for (int budget = 0; budget < 60 && exp_q.size() > 0; budget++) begin
      @(negedge clk);
      since++;
      if (rearm0) begin
        set_port(0, 1'b1, 1'b0, 4'h0, 8'h00);
        rearm0 = 1'b0;
      end
      if (rdy != 4'h0) begin
        p = exp_q.pop_front();
        d = expd_q.pop_front();
        check("rr_order", 32'(rdy), 32'(4'b0001 << p));
        check("rr_spacing", 32'(since), (served == 0) ? 32'(LAT) : 32'(LAT + 1));
        check("rr_rdata", 32'(rdata[int'(p)*8 +: 8]), 32'(d));
        since = 0;
        served++;
        set_port(int'(p), 1'b0, 1'b0, 4'h0, 8'h00);
        if (served == 1) rearm0 = 1'b1;
      end
    end
    check("rr_all_served", 32'(exp_q.size()), 32'h0);

    // Write whose request is dropped mid-BUSY still completes and commits.
    @(negedge clk);
    set_port(1, 1'b0, 1'b1, 4'h3, 8'h3C);
    @(negedge clk);
    check("drop_other_rdy", 32'(rdy), 32'h0);
    set_port(1, 1'b0, 1'b0, 4'h3, 8'h3C);
    wait_rdy(1, 1, lat);
    check("drop_latency", 32'(lat), 32'(LAT));
    access(1, 1'b1, 1'b0, 4'h3, 8'h00, 8'h3C, "drop_readback");
`ifdef MEM_REQ_CHECK_EN
    check("drop_proto_err", 32'(proto_err), 32'h2);
`endif

    // Reset during BUSY of a write: no rdy, no store update, store cleared.
    @(negedge clk);
    set_port(0, 1'b0, 1'b1, 4'h2, 8'h77);
    @(negedge clk);
    rst = 1'b0;
    rd = '0; wr = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_rdy", 32'(rdy), 32'h0);
      check("abort_rdata", rdata, 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_late_rdy", 32'(rdy), 32'h0);
    end
`ifdef MEM_REQ_CHECK_EN
    check("abort_proto_err", 32'(proto_err), 32'h0);
`endif
    access(0, 1'b1, 1'b0, 4'h2, 8'h00, 8'h00, "abort_readback");
    access(2, 1'b1, 1'b0, 4'h5, 8'h00, 8'h00, "abort_cleared");

    // rd and wr together on port 3 is a write.
    access(3, 1'b1, 1'b1, 4'h9, 8'h99, 8'h00, "rdwr");
`ifdef MEM_REQ_CHECK_EN
    check("rdwr_proto_err", 32'(proto_err), 32'h8);
    repeat (3) @(negedge clk);
    check("rdwr_proto_err_held", 32'(proto_err), 32'h8);
`endif
    access(0, 1'b1, 1'b0, 4'h9, 8'h00, 8'h99, "rdwr_readback");

    apply_reset();
    @(negedge clk);
    check("final_rdata", rdata, 32'h0);
`ifdef MEM_REQ_CHECK_EN
    check("final_proto_err", 32'(proto_err), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
